// File: rtl/muldiv_pkg.sv
// Shared opcode and timing definitions for the integer datapath: ALU ops,
// multiply/divide ops, default multiply/divide latencies.
package muldiv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } md_state_e;

    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;

    function automatic int maxCycles(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the pipeline (master) and the mul/div unit (slave).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, src_a, src_b, cancel, input busy, hi, lo);
    modport slave  (input start, op, src_a, src_b, cancel, output busy, hi, lo);
endinterface

// File: rtl/muldiv_unit_calc.sv
// Single-cycle HI/LO result for MULT/MULTU/DIV/DIVU; the top holds it in a
// register until the visible latency has elapsed.
module muldiv_unit_calc
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_srcA,
    input  logic [WIDTH-1:0] i_srcB,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic               w_aNeg;
    logic               w_bNeg;

    // Signed divide works on magnitudes; MIN/-1 falls out naturally as MIN, rem 0.
    always_comb begin
        w_prod = '0;
        w_quot = '0;
        w_rem  = '0;
        o_hi   = '0;
        o_lo   = '0;
        w_aNeg = i_srcA[WIDTH-1];
        w_bNeg = i_srcB[WIDTH-1];
        w_absA = w_aNeg ? -i_srcA : i_srcA;
        w_absB = w_bNeg ? -i_srcB : i_srcB;
        case (i_op)
            OP_MULT: begin
                w_prod = {{WIDTH{i_srcA[WIDTH-1]}}, i_srcA} * {{WIDTH{i_srcB[WIDTH-1]}}, i_srcB};
                o_hi   = w_prod[2*WIDTH-1:WIDTH];
                o_lo   = w_prod[WIDTH-1:0];
            end
            OP_MULTU: begin
                w_prod = {{WIDTH{1'b0}}, i_srcA} * {{WIDTH{1'b0}}, i_srcB};
                o_hi   = w_prod[2*WIDTH-1:WIDTH];
                o_lo   = w_prod[WIDTH-1:0];
            end
            OP_DIV: begin
                if (i_srcB == '0) begin
                    o_hi = i_srcA;
                    o_lo = '1;
                end else begin
                    w_quot = w_absA / w_absB;
                    w_rem  = w_absA % w_absB;
                    o_lo   = (w_aNeg ^ w_bNeg) ? -w_quot : w_quot;
                    o_hi   = w_aNeg ? -w_rem : w_rem;
                end
            end
            OP_DIVU: begin
                if (i_srcB == '0) begin
                    o_hi = i_srcA;
                    o_lo = '1;
                end else begin
                    o_lo = i_srcA / i_srcB;
                    o_hi = i_srcA % i_srcB;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: result computed at issue, held, and committed
// to HI/LO exactly MUL_CYCLES/DIV_CYCLES cycles later unless cancelled.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input logic      clk,
    input logic      reset_n,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(maxCycles(MUL_CYCLES, DIV_CYCLES) + 1);

    md_state_e        r_state;
    md_state_e        w_stateNext;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cntNext;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_resHi;
    logic [WIDTH-1:0] r_resLo;
    logic [WIDTH-1:0] w_hiNext;
    logic [WIDTH-1:0] w_loNext;
    logic [WIDTH-1:0] w_resHiNext;
    logic [WIDTH-1:0] w_resLoNext;
    logic [WIDTH-1:0] w_calcHi;
    logic [WIDTH-1:0] w_calcLo;

    muldiv_unit_calc #(.WIDTH(WIDTH)) u_calc (
        .i_op   (bus.op),
        .i_srcA (bus.src_a),
        .i_srcB (bus.src_b),
        .o_hi   (w_calcHi),
        .o_lo   (w_calcLo)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_resHi <= '0;
            r_resLo <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_hi    <= w_hiNext;
            r_lo    <= w_loNext;
            r_resHi <= w_resHiNext;
            r_resLo <= w_resLoNext;
        end
    end

    // Cancel outranks both issue and commit; the held result is simply dropped.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_hiNext    = r_hi;
        w_loNext    = r_lo;
        w_resHiNext = r_resHi;
        w_resLoNext = r_resLo;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            w_stateNext = ST_BUSY;
                            w_cntNext   = CW'(MUL_CYCLES);
                            w_resHiNext = w_calcHi;
                            w_resLoNext = w_calcLo;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_stateNext = ST_BUSY;
                            w_cntNext   = CW'(DIV_CYCLES);
                            w_resHiNext = w_calcHi;
                            w_resLoNext = w_calcLo;
                        end
                        OP_MTHI: w_hiNext = bus.src_a;
                        OP_MTLO: w_loNext = bus.src_a;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (bus.cancel) begin
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                end else if (r_cnt == CW'(1)) begin
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                    w_hiNext    = r_resHi;
                    w_loNext    = r_resLo;
                end else begin
                    w_cntNext = r_cnt - CW'(1);
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    assign bus.busy = (r_state == ST_BUSY);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: each MULT/DIV pushes its expected HI/LO and
// busy length; a monitor checks them whenever busy falls.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk;
    logic reset_n;
    int   passCount;
    int   checkCount;
    int   busyRun;
    logic prevBusy;
    exp_t sbQ[$];

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    endtask

    // Monitor: a falling busy marks a finished (or aborted) op.
    initial begin
        busyRun  = 0;
        prevBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) busyRun++;
            if (prevBusy === 1'b1 && bus.busy === 1'b0) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("sb_busy_cycles", 32'(busyRun), 32'(e.cycles));
                    checkOutput("sb_hi", bus.hi, e.hi);
                    checkOutput("sb_lo", bus.lo, e.lo);
                end
                busyRun = 0;
            end
            prevBusy = bus.busy;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.src_a = 32'hDEADBEEF;
        bus.src_b = 32'h0BADF00D;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200; i++) begin
            if (bus.busy !== 1'b1) break;
            @(posedge clk);
            #1;
        end
        if (bus.busy !== 1'b0) begin
            checkOutput("busy_timeout", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eHi, input logic [31:0] eLo, input int eCyc);
        exp_t e;
        e.hi = eHi;
        e.lo = eLo;
        e.cycles = eCyc;
        sbQ.push_back(e);
        issue(op, a, b);
        waitIdle();
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = 3'd0;
        bus.src_a  = '0;
        bus.src_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_hi", bus.hi, 32'd0);
        checkOutput("reset_lo", bus.lo, 32'd0);
        reset_n = 1'b1;

        applyStimulus(OP_MULT, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);
        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
        applyStimulus(OP_DIV, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        applyStimulus(OP_DIV, 32'd7, -32'sd2, 32'h00000001, 32'hFFFFFFFD, 10);
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        applyStimulus(OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 10);
        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);

        // Cancel in busy cycle 3: HI/LO keep 0 / 0x80000000.
        sbQ.push_back('{hi: 32'd0, lo: 32'h80000000, cycles: 3});
        issue(OP_MULTU, 32'd5, 32'd6);
        repeat (2) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        checkOutput("cancel_busy", 32'(bus.busy), 32'd0);
        applyStimulus(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 5);

        // Starts while busy are dropped.
        sbQ.push_back('{hi: 32'd0, lo: 32'd6, cycles: 5});
        issue(OP_MULT, 32'd2, 32'd3);
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.src_a = 32'h55;
        repeat (2) @(posedge clk);
        #1;
        bus.op    = OP_DIV;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitIdle();

        issue(OP_MTHI, 32'hAA, 32'd0);
        checkOutput("mthi_hi", bus.hi, 32'hAA);
        checkOutput("mthi_lo", bus.lo, 32'd6);
        checkOutput("mthi_busy", 32'(bus.busy), 32'd0);
        issue(OP_MTLO, 32'hBB, 32'd0);
        checkOutput("mtlo_hi", bus.hi, 32'hAA);
        checkOutput("mtlo_lo", bus.lo, 32'hBB);

        for (int c = 6; c < 8; c++) begin
            issue(3'(c), 32'h99, 32'h3);
            checkOutput("noop_hi", bus.hi, 32'hAA);
            checkOutput("noop_lo", bus.lo, 32'hBB);
            checkOutput("noop_busy", 32'(bus.busy), 32'd0);
        end

        bus.cancel = 1'b1;
        issue(OP_MTHI, 32'h11, 32'd0);
        checkOutput("cancel_mthi_hi", bus.hi, 32'hAA);
        issue(OP_MULT, 32'd2, 32'd2);
        bus.cancel = 1'b0;
        checkOutput("cancel_start_busy", 32'(bus.busy), 32'd0);

        // Start held through the falling-busy cycle is taken one cycle later.
        sbQ.push_back('{hi: 32'd0, lo: 32'd12, cycles: 5});
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = OP_MTLO;
        bus.src_a = 32'h77;
        @(posedge clk);
        #1;
        checkOutput("fall_edge_lo", bus.lo, 32'd12);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("late_mtlo_lo", bus.lo, 32'h77);
        checkOutput("late_mtlo_hi", bus.hi, 32'd0);

        // Reset in the middle of a divide.
        sbQ.push_back('{hi: 32'd0, lo: 32'd0, cycles: 4});
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_mid_hi", bus.hi, 32'd0);
        checkOutput("rst_mid_lo", bus.lo, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
